// File: rtl/aidc_lite_comp_sched.sv
// aidc_lite_comp_sched: pick the shortest successful compression of a line (else raw) and stream it out
module aidc_lite_comp_sched #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [511:0] raw_i,
  input  logic         c0_valid_i,
  input  logic [2:0]   c0_addr_i,
  input  logic [63:0]  c0_data_i,
  input  logic         c0_done_i,
  input  logic         c0_fail_i,
  input  logic         c1_valid_i,
  input  logic [2:0]   c1_addr_i,
  input  logic [63:0]  c1_data_i,
  input  logic         c1_done_i,
  input  logic         c1_fail_i,
  output logic         busy_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [63:0]  out_data_o,
  output logic         out_sop_o,
  output logic         out_eop_o,
  output logic [1:0]   out_mode_o,
  output logic [3:0]   out_len_o
);
  typedef enum logic [1:0] {IDLE, WAIT, SEL, SEND} state_t;
  localparam int TW = $clog2(TIMEOUT) + 1;
  state_t         state;
  logic [511:0]   raw_q;
  logic [63:0]    buf0 [8];
  logic [63:0]    buf1 [8];
  logic [3:0]     cnt0, cnt1, a0, a1;
  logic           done0, done1, fail0, fail1, prev0, prev1;
  logic           rise0, rise1, e0, e1, pick0;
  logic [TW-1:0]  timer;
  logic [2:0]     idx;
  logic [8:0]     sh;
  assign busy_o = state != IDLE;
  // selection, done-edge detection and output word mux
  always_comb begin
    rise0 = c0_done_i & ~prev0;
    rise1 = c1_done_i & ~prev1;
    e0 = done0 & ~fail0 & (cnt0 != 4'd0);
    e1 = done1 & ~fail1 & (cnt1 != 4'd0);
    pick0 = e0 & (~e1 | (cnt0 <= cnt1));
    a0 = {1'b0, c0_addr_i} + 4'd1;
    a1 = {1'b0, c1_addr_i} + 4'd1;
    sh = {~idx, 6'd0};
    out_data_o = out_mode_o == 2'b00 ? buf0[idx] : out_mode_o == 2'b01 ? buf1[idx] : raw_q[sh +: 64];
  end
  // line and candidate storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (state == IDLE && start_i) raw_q <= raw_i;
    if (state == WAIT && c0_valid_i) buf0[c0_addr_i] <= c0_data_i;
    if (state == WAIT && c1_valid_i) buf1[c1_addr_i] <= c1_data_i;
  end
  // control FSM with registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt0 <= '0;
      cnt1 <= '0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      fail0 <= 1'b0;
      fail1 <= 1'b0;
      prev0 <= 1'b1;
      prev1 <= 1'b1;
      timer <= '0;
      idx <= '0;
      out_valid_o <= 1'b0;
      out_sop_o <= 1'b0;
      out_eop_o <= 1'b0;
      out_mode_o <= 2'b00;
      out_len_o <= '0;
    end else begin
      prev0 <= c0_done_i;
      prev1 <= c1_done_i;
      case (state)
        IDLE: if (start_i) begin
          cnt0 <= '0;
          cnt1 <= '0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          fail0 <= 1'b0;
          fail1 <= 1'b0;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (c0_valid_i && a0 > cnt0) cnt0 <= a0;
          if (c1_valid_i && a1 > cnt1) cnt1 <= a1;
          if (rise0) begin
            done0 <= 1'b1;
            fail0 <= c0_fail_i;
          end
          if (rise1) begin
            done1 <= 1'b1;
            fail1 <= c1_fail_i;
          end
          if ((done0 && done1) || timer == TW'(TIMEOUT - 1)) state <= SEL;
        end
        SEL: begin
          out_mode_o <= pick0 ? 2'b00 : e1 ? 2'b01 : 2'b11;
          out_len_o <= pick0 ? cnt0 : e1 ? cnt1 : 4'd8;
          out_eop_o <= pick0 ? cnt0 == 4'd1 : e1 && cnt1 == 4'd1;
          out_sop_o <= 1'b1;
          out_valid_o <= 1'b1;
          idx <= '0;
          state <= SEND;
        end
        SEND: if (out_ready_i) begin
          if (out_eop_o) begin
            out_valid_o <= 1'b0;
            out_sop_o <= 1'b0;
            out_eop_o <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx + 3'd1;
            out_sop_o <= 1'b0;
            out_eop_o <= {1'b0, idx} + 4'd2 == out_len_o;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aidc_lite_comp_sched.sv
// tb_aidc_lite_comp_sched: randomized packets checked against a selection/stream reference model
module tb_aidc_lite_comp_sched;
  logic clk = 0, rst = 1, start_i = 0;
  logic [511:0] raw_i = '0;
  logic c0_valid_i = 0, c1_valid_i = 0;
  logic [2:0] c0_addr_i = 0, c1_addr_i = 0;
  logic [63:0] c0_data_i = 0, c1_data_i = 0;
  logic c0_done_i = 0, c1_done_i = 0, c0_fail_i = 0, c1_fail_i = 0;
  logic busy_o, out_valid_o, out_ready_i = 0, out_sop_o, out_eop_o;
  logic [63:0] out_data_o;
  logic [1:0] out_mode_o;
  logic [3:0] out_len_o;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  aidc_lite_comp_sched dut (
    .clk(clk), .rst(rst), .start_i(start_i), .raw_i(raw_i),
    .c0_valid_i(c0_valid_i), .c0_addr_i(c0_addr_i), .c0_data_i(c0_data_i), .c0_done_i(c0_done_i), .c0_fail_i(c0_fail_i),
    .c1_valid_i(c1_valid_i), .c1_addr_i(c1_addr_i), .c1_data_i(c1_data_i), .c1_done_i(c1_done_i), .c1_fail_i(c1_fail_i),
    .busy_o(busy_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_sop_o(out_sop_o), .out_eop_o(out_eop_o), .out_mode_o(out_mode_o), .out_len_o(out_len_o)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // one full transaction: start, candidate writes/dones, then drain and check the stream
  task automatic pkt(input int w0, input int w1, input bit d0, input bit d1, input bit f0, input bit f1,
                     input int rm, input bit rst_at2);
    logic [511:0] rv;
    logic [63:0] b0 [8];
    logic [63:0] b1 [8];
    logic [63:0] exp [$];
    logic [63:0] prev;
    int l, emode, elen, cyc, k, fv, rc;
    bit e0, e1, stall, r;
    for (int i = 0; i < 16; i++) rv[32*i +: 32] = $urandom;
    start_i = 1;
    raw_i = rv;
    c0_done_i = 0; c1_done_i = 0; c0_fail_i = 0; c1_fail_i = 0;
    tick;
    cyc = 0;
    l = w0 > w1 ? w0 : w1;
    if (l < 1) l = 1;
    for (int j = 0; j < l; j++) begin
      start_i = j == 0;
      raw_i = ~rv;
      c0_valid_i = j < w0; c0_addr_i = 3'(j); c0_data_i = {$urandom, $urandom};
      c1_valid_i = j < w1; c1_addr_i = 3'(j); c1_data_i = {$urandom, $urandom};
      if (j < w0) b0[j] = c0_data_i;
      if (j < w1) b1[j] = c1_data_i;
      if (d0 && j == (w0 > 0 ? w0 - 1 : 0)) begin c0_done_i = 1; c0_fail_i = f0; end
      if (d1 && j == (w1 > 0 ? w1 - 1 : 0)) begin c1_done_i = 1; c1_fail_i = f1; end
      tick;
      cyc++;
    end
    start_i = 0; c0_valid_i = 0; c1_valid_i = 0;
    e0 = d0 && !f0 && w0 > 0;
    e1 = d1 && !f1 && w1 > 0;
    if (e0 && (!e1 || w0 <= w1)) begin
      emode = 0; elen = w0;
      for (int i = 0; i < w0; i++) exp.push_back(b0[i]);
    end else if (e1) begin
      emode = 1; elen = w1;
      for (int i = 0; i < w1; i++) exp.push_back(b1[i]);
    end else begin
      emode = 3; elen = 8;
      for (int i = 0; i < 8; i++) exp.push_back(rv[511-64*i -: 64]);
    end
    k = 0; fv = -1; rc = 0; stall = 0; prev = '0;
    for (int t = 0; t < 400 && k < elen; t++) begin
      if (out_valid_o) begin
        if (fv < 0) fv = cyc;
        if (stall) chk("hold", out_data_o, prev);
        chk("data", out_data_o, exp[k]);
        chk("sop", 64'(out_sop_o), 64'(k == 0));
        chk("eop", 64'(out_eop_o), 64'(k == elen - 1));
        chk("mode", 64'(out_mode_o), 64'(emode));
        chk("len", 64'(out_len_o), 64'(elen));
        if (rst_at2 && k == 2) begin
          rst = 1;
          out_ready_i = 0;
          tick;
          rst = 0;
          chk("rst_valid", 64'(out_valid_o), 0);
          chk("rst_busy", 64'(busy_o), 0);
          return;
        end
        r = rm == 1 ? 1'b1 : rm == 2 ? (rc % 3 == 0) : 1'($urandom_range(0, 1));
        rc++;
        out_ready_i = r;
        stall = !r;
        prev = out_data_o;
        if (r) k++;
      end else begin
        out_ready_i = 1'($urandom_range(0, 1));
        stall = 0;
      end
      tick;
      cyc++;
    end
    out_ready_i = 0;
    chk("words", 64'(k), 64'(elen));
    chk("end_busy", 64'(busy_o), 0);
    chk("end_valid", 64'(out_valid_o), 0);
    if (!(d0 && d1)) chk("tmo_lat", 64'(fv), 65);
  endtask
  initial begin
    rst = 1;
    repeat (3) tick;
    chk("rst_busy0", 64'(busy_o), 0);
    chk("rst_valid0", 64'(out_valid_o), 0);
    chk("rst_sop0", 64'(out_sop_o), 0);
    chk("rst_eop0", 64'(out_eop_o), 0);
    chk("rst_mode0", 64'(out_mode_o), 0);
    chk("rst_len0", 64'(out_len_o), 0);
    rst = 0;
    pkt(3, 5, 1, 1, 0, 0, 1, 0);
    pkt(8, 2, 1, 1, 1, 0, 0, 0);
    pkt(4, 4, 1, 1, 1, 1, 0, 0);
    pkt(2, 3, 1, 0, 0, 0, 0, 0);
    pkt(2, 3, 0, 0, 0, 0, 0, 0);
    pkt(4, 6, 1, 1, 0, 0, 2, 0);
    pkt(3, 3, 1, 1, 0, 0, 1, 0);
    pkt(1, 4, 1, 1, 0, 0, 0, 0);
    pkt(6, 8, 1, 1, 0, 0, 1, 1);
    pkt(5, 2, 1, 1, 0, 0, 0, 0);
    repeat (25) pkt($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
